// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_port_arbiter
//  Description : Round-robin arbiter sharing a word-only, single-port data
//                memory between a read-only port (port 0) and a load/store
//                port (port 1). Sub-word stores run as a two-cycle
//                read-modify-write. Load data returns one cycle after grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   // port 0 : read-only requester
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   // port 1 : load/store unit
   input  logic              req1,
   input  logic              we1,
   input  logic [1:0]        size1,
   input  logic              uns1,
   input  logic [ADDR_W+1:0] baddr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              err1,
   // memory side
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] c_SIZE_BYTE = 2'b00;
   localparam logic [1:0] c_SIZE_HALF = 2'b01;
   localparam logic [1:0] c_SIZE_WORD = 2'b10;
   localparam logic [1:0] c_SIZE_BAD  = 2'b11;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RMW  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   // 1 = port 1 received the most recent grant
   logic                r_last_grant;

   // registered response side
   logic                r_rvalid0;
   logic                r_rvalid1;
   logic                r_err1;
   logic [DATA_W-1:0]   r_rdata0;
   logic [DATA_W-1:0]   r_rdata1;

   // read-modify-write context captured on the sub-word store grant
   logic [DATA_W-1:0]   r_rmw_old;
   logic [15:0]         r_rmw_wdata;
   logic                r_rmw_is_byte;
   logic [1:0]          r_rmw_off;
   logic [ADDR_W-1:0]   r_rmw_addr;

   logic [1:0]          w_off1;
   logic [ADDR_W-1:0]   w_waddr1;
   logic                w_err1;
   logic                w_pick0;
   logic                w_load1;
   logic                w_rmw_start;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [DATA_W-1:0]   w_load_ext;
   logic [DATA_W-1:0]   w_merged;

   assign w_off1   = baddr1[1:0];
   assign w_waddr1 = baddr1[ADDR_W+1:2];

   // Port 0 wins when alone, or on a tie when port 1 was served last
   assign w_pick0 = req0 & (~req1 | r_last_grant);

   // Illegal size or misaligned access on port 1
   always_comb begin
      w_err1 = 1'b0;
      unique case (size1)
         c_SIZE_BYTE: w_err1 = 1'b0;
         c_SIZE_HALF: w_err1 = w_off1[0];
         c_SIZE_WORD: w_err1 = (w_off1 != 2'b00);
         c_SIZE_BAD:  w_err1 = 1'b1;
         default:     w_err1 = 1'b1;
      endcase
   end

   // Arbitration, memory control and next-state decode
   always_comb begin
      w_state_nxt = r_state;
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      w_load1     = 1'b0;
      w_rmw_start = 1'b0;
      // Reset suppresses every grant and memory enable, including a pending RMW write
      if (!rst) begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_pick0) begin
                  gnt0     = 1'b1;
                  mem_read = 1'b1;
                  mem_addr = addr0;
               end else if (req1) begin
                  gnt1 = 1'b1;
                  if (w_err1) begin
                     // rejected: consumes the grant slot, touches no memory
                     w_load1 = 1'b0;
                  end else if (!we1) begin
                     mem_read = 1'b1;
                     mem_addr = w_waddr1;
                     w_load1  = 1'b1;
                  end else if (size1 == c_SIZE_WORD) begin
                     mem_write = 1'b1;
                     mem_addr  = w_waddr1;
                     mem_wdata = wdata1;
                  end else begin
                     // sub-word store: fetch the old word now, write it back next cycle
                     mem_read    = 1'b1;
                     mem_addr    = w_waddr1;
                     w_rmw_start = 1'b1;
                     w_state_nxt = ST_RMW;
                  end
               end
            end
            ST_RMW: begin
               mem_write   = 1'b1;
               mem_addr    = r_rmw_addr;
               mem_wdata   = w_merged;
               w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Lane select and sign/zero extension of port 1 load data
   always_comb begin
      w_byte = mem_rdata[7:0];
      unique case (w_off1)
         2'd0: w_byte = mem_rdata[7:0];
         2'd1: w_byte = mem_rdata[15:8];
         2'd2: w_byte = mem_rdata[23:16];
         2'd3: w_byte = mem_rdata[31:24];
         default: w_byte = mem_rdata[7:0];
      endcase
      w_half     = w_off1[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      w_load_ext = mem_rdata;
      if (size1 == c_SIZE_BYTE) begin
         w_load_ext = uns1 ? {{(DATA_W-8){1'b0}}, w_byte}
                           : {{(DATA_W-8){w_byte[7]}}, w_byte};
      end else if (size1 == c_SIZE_HALF) begin
         w_load_ext = uns1 ? {{(DATA_W-16){1'b0}}, w_half}
                           : {{(DATA_W-16){w_half[15]}}, w_half};
      end
   end

   // Old word with the stored byte or half lane replaced
   always_comb begin
      w_merged = r_rmw_old;
      if (r_rmw_is_byte) begin
         unique case (r_rmw_off)
            2'd0: w_merged[7:0]   = r_rmw_wdata[7:0];
            2'd1: w_merged[15:8]  = r_rmw_wdata[7:0];
            2'd2: w_merged[23:16] = r_rmw_wdata[7:0];
            2'd3: w_merged[31:24] = r_rmw_wdata[7:0];
            default: w_merged = r_rmw_old;
         endcase
      end else if (r_rmw_off[1]) begin
         w_merged[31:16] = r_rmw_wdata;
      end else begin
         w_merged[15:0]  = r_rmw_wdata;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Round-robin history, updated on every grant including rejected ones
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= 1'b1;
      end else if (gnt0) begin
         r_last_grant <= 1'b0;
      end else if (gnt1) begin
         r_last_grant <= 1'b1;
      end
   end

   // Single-cycle response pulses following each grant
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_err1    <= 1'b0;
      end else begin
         r_rvalid0 <= gnt0;
         r_rvalid1 <= w_load1;
         r_err1    <= gnt1 & w_err1;
      end
   end

   // Read data registers, holding their last value between loads
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         if (gnt0) begin
            r_rdata0 <= mem_rdata;
         end
         if (w_load1) begin
            r_rdata1 <= w_load_ext;
         end
      end
   end

   // Capture the read-modify-write context on a sub-word store grant
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rmw_old     <= '0;
         r_rmw_wdata   <= '0;
         r_rmw_is_byte <= 1'b0;
         r_rmw_off     <= '0;
         r_rmw_addr    <= '0;
      end else if (w_rmw_start) begin
         r_rmw_old     <= mem_rdata;
         r_rmw_wdata   <= wdata1[15:0];
         r_rmw_is_byte <= (size1 == c_SIZE_BYTE);
         r_rmw_off     <= w_off1;
         r_rmw_addr    <= w_waddr1;
      end
   end

   assign rvalid0 = r_rvalid0;
   assign rvalid1 = r_rvalid1;
   assign err1    = r_err1;
   assign rdata0  = r_rdata0;
   assign rdata1  = r_rdata1;

endmodule
`default_nettype wire
